// File: rtl/ccff_chain_loader.sv
`default_nettype none
// ============================================================================
// Module      : ccff_chain_loader
// Description : Loads the fabric configuration chain. Bitstream words come in
//               over a valid/ready stream and are shifted out MSB-first on
//               ccff_head. The chain clock is gated by ccff_clk_en, and exactly
//               CHAIN_LEN bits are shifted before done pulses. A one-word
//               holding buffer lets the next word be taken while the current
//               one is still shifting, so streaming has no gaps.
//
// Ports       : prog_clk, prog_reset  - clock, synchronous active-high reset
//               start, abort          - begin load (IDLE only) / cancel load
//               s_data/s_valid/s_ready- bitstream word stream
//               ccff_head, ccff_tail  - chain head output / chain tail return
//               ccff_clk_en           - chain shifts on prog_clk when high
//               busy, done, aborted   - status and one-cycle pulses
//               bits_loaded           - bits shifted in current/last load
//               tail_crc              - CRC-16-CCITT of the tail stream
//                                       (only with CCFF_TAIL_CRC_EN)
//
// Options     : `define CCFF_TAIL_CRC_EN adds the tail_crc readback output.
// Revision    : 1.0 - initial release
// ============================================================================
module ccff_chain_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 1024,
    parameter int CNT_W     = 11
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              ccff_clk_en,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [CNT_W-1:0]  bits_loaded
`ifdef CCFF_TAIL_CRC_EN
    ,
    output logic [15:0]       tail_crc
`endif
);

    localparam int c_WIDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [c_WIDX_W-1:0] c_WIDX_LAST = c_WIDX_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0]    c_LAST_BIT  = CNT_W'(CHAIN_LEN - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WAIT  = 2'd1;
    localparam logic [1:0] c_SHIFT = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]          r_state;
    logic [WORD_W-1:0]   r_sreg;
    logic [c_WIDX_W-1:0] r_widx;
    logic [WORD_W-1:0]   r_hbuf;
    logic                r_hvalid;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_aborted;

    logic [1:0]          w_state_nxt;
    logic [WORD_W-1:0]   w_sreg_nxt;
    logic [c_WIDX_W-1:0] w_widx_nxt;
    logic [WORD_W-1:0]   w_hbuf_nxt;
    logic                w_hvalid_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_aborted_nxt;
    logic                w_fire;

    assign s_ready     = ((r_state == c_WAIT) || (r_state == c_SHIFT)) && !r_hvalid;
    assign w_fire      = s_valid && s_ready;
    assign ccff_head   = r_sreg[WORD_W-1];
    assign ccff_clk_en = (r_state == c_SHIFT);
    assign busy        = (r_state != c_IDLE);
    // An abort landing in the DONE cycle cancels the completion pulse so that
    // exactly one of done/aborted reports the end of a load.
    assign done        = (r_state == c_DONE) && !abort;
    assign aborted     = r_aborted;
    assign bits_loaded = r_cnt;

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            r_state   <= c_IDLE;
            r_sreg    <= '0;
            r_widx    <= '0;
            r_hbuf    <= '0;
            r_hvalid  <= 1'b0;
            r_cnt     <= '0;
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sreg    <= w_sreg_nxt;
            r_widx    <= w_widx_nxt;
            r_hbuf    <= w_hbuf_nxt;
            r_hvalid  <= w_hvalid_nxt;
            r_cnt     <= w_cnt_nxt;
            r_aborted <= w_aborted_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_sreg_nxt    = r_sreg;
        w_widx_nxt    = r_widx;
        w_hbuf_nxt    = r_hbuf;
        w_hvalid_nxt  = r_hvalid;
        w_cnt_nxt     = r_cnt;
        w_aborted_nxt = 1'b0;

        if ((r_state != c_IDLE) && abort) begin
            // Counter is frozen so the host can see how far the load got.
            w_state_nxt   = c_IDLE;
            w_hvalid_nxt  = 1'b0;
            w_aborted_nxt = 1'b1;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        w_state_nxt  = c_WAIT;
                        w_cnt_nxt    = '0;
                        w_hvalid_nxt = 1'b0;
                    end
                end
                c_WAIT: begin
                    if (w_fire) begin
                        w_sreg_nxt  = s_data;
                        w_widx_nxt  = '0;
                        w_state_nxt = c_SHIFT;
                    end
                end
                c_SHIFT: begin
                    w_sreg_nxt = r_sreg << 1;
                    w_widx_nxt = r_widx + c_WIDX_W'(1);
                    w_cnt_nxt  = r_cnt + CNT_W'(1);
                    if (r_cnt == c_LAST_BIT) begin
                        // Final chain bit: leftover word bits are dropped.
                        w_state_nxt  = c_DONE;
                        w_hvalid_nxt = 1'b0;
                    end else if (r_widx == c_WIDX_LAST) begin
                        w_widx_nxt = '0;
                        if (r_hvalid) begin
                            w_sreg_nxt   = r_hbuf;
                            w_hvalid_nxt = 1'b0;
                        end else if (w_fire) begin
                            w_sreg_nxt = s_data;
                        end else begin
                            // Starved: chain clock stops until a word arrives.
                            w_state_nxt = c_WAIT;
                        end
                    end else if (w_fire) begin
                        w_hbuf_nxt   = s_data;
                        w_hvalid_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = c_IDLE;
                end
            endcase
        end
    end

`ifdef CCFF_TAIL_CRC_EN
    // CRC-16-CCITT, MSB-first, over every bit leaving the chain tail.
    logic [15:0] r_crc;
    logic        w_crc_fb;

    assign w_crc_fb = r_crc[15] ^ ccff_tail;

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            r_crc <= 16'hFFFF;
        end else if ((r_state == c_IDLE) && start) begin
            r_crc <= 16'hFFFF;
        end else if (ccff_clk_en) begin
            r_crc <= {r_crc[14:0], 1'b0} ^ (w_crc_fb ? 16'h1021 : 16'h0000);
        end
    end

    assign tail_crc = r_crc;
`else
    logic w_unused_tail;
    assign w_unused_tail = ccff_tail;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ccff_chain_loader
// Description : Self-checking bench for ccff_chain_loader (WORD_W=8,
//               CHAIN_LEN=20). Expected shift cycles and bits come from an
//               arithmetic timing model of word acceptance and streaming.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ccff_chain_loader;
    localparam int WORD_W    = 8;
    localparam int CHAIN_LEN = 20;
    localparam int CNT_W     = 5;

    logic              prog_clk = 1'b0;
    logic              prog_reset = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [WORD_W-1:0] s_data = '0;
    logic              s_valid = 1'b0;
    logic              s_ready, ccff_head, ccff_tail, ccff_clk_en;
    logic              busy, done, aborted;
    logic [CNT_W-1:0]  bits_loaded;
`ifdef CCFF_TAIL_CRC_EN
    logic [15:0]       tail_crc;
`endif

    ccff_chain_loader #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN), .CNT_W(CNT_W)) dut (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .ccff_head(ccff_head),
        .ccff_tail(ccff_tail), .ccff_clk_en(ccff_clk_en), .busy(busy), .done(done),
        .aborted(aborted), .bits_loaded(bits_loaded)
`ifdef CCFF_TAIL_CRC_EN
        , .tail_crc(tail_crc)
`endif
    );

    always #5 prog_clk = ~prog_clk;

    // Behavioural model of the configuration chain itself.
    logic [CHAIN_LEN-1:0] chain = '0;
    always @(posedge prog_clk) if (ccff_clk_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
    assign ccff_tail = chain[CHAIN_LEN-1];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [WORD_W-1:0] feed_data[$];
    int                feed_at[$];
    logic [WORD_W-1:0] mw[$];
    int                mat[$];
    int                obs_en[$];
    bit                obs_bit[$];
    int                obs_done[$];
    int                obs_ab[$];
    int                exp_t[$];
    bit                exp_b[$];

    logic [CHAIN_LEN-1:0] ref_bits = 20'b10100101001111001111;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic drive_feed();
        if (feed_data.size() > 0 && cyc >= feed_at[0]) begin
            s_valid = 1'b1;
            s_data  = feed_data[0];
        end else begin
            s_valid = 1'b0;
            s_data  = WORD_W'($urandom);
        end
    endtask

    // One clock cycle: observe at the falling edge, advance after the rising edge.
    task automatic tick();
        bit fire;
        @(negedge prog_clk);
        fire = s_valid && s_ready;
        if (ccff_clk_en) begin obs_en.push_back(cyc); obs_bit.push_back(ccff_head); end
        if (done)    obs_done.push_back(cyc);
        if (aborted) obs_ab.push_back(cyc);
        @(posedge prog_clk);
        #1;
        cyc++;
        if (fire && feed_data.size() > 0) begin
            void'(feed_data.pop_front());
            void'(feed_at.pop_front());
        end
        start = 1'b0;
        abort = 1'b0;
        drive_feed();
    endtask

    task automatic begin_test();
        obs_en.delete(); obs_bit.delete(); obs_done.delete(); obs_ab.delete();
        feed_data.delete(); feed_at.delete(); mw.delete(); mat.delete();
        cyc = 0;
        drive_feed();
    endtask

    task automatic load_feed();
        feed_data.delete(); feed_at.delete();
        foreach (mw[k]) begin feed_data.push_back(mw[k]); feed_at.push_back(mat[k]); end
        drive_feed();
    endtask

    task automatic basic_words(input int t1, input int t2);
        mw = '{8'hA5, 8'h3C, 8'hF0};
        mat = '{0, t1, t2};
        load_feed();
    endtask

    task automatic random_words(input int nw, input int gap);
        int t;
        t = $urandom_range(0, gap);
        for (int k = 0; k < nw; k++) begin
            mw.push_back(WORD_W'($urandom));
            mat.push_back(t);
            t += $urandom_range(0, gap);
        end
        load_feed();
    endtask

    // Word k is taken once it is offered and the previous word has started
    // shifting; its bits follow back-to-back unless it arrives late.
    task automatic build_model(input int s);
        int a, st, prev;
        exp_t.delete(); exp_b.delete();
        prev = 0;
        for (int k = 0; k < mw.size() && exp_t.size() < CHAIN_LEN; k++) begin
            if (k == 0) begin a = imax(mat[0], s + 1); st = a + 1; end
            else begin a = imax(mat[k], prev); st = imax(prev + WORD_W, a + 1); end
            prev = st;
            for (int j = 0; j < WORD_W && exp_t.size() < CHAIN_LEN; j++) begin
                exp_t.push_back(st + j);
                exp_b.push_back(mw[k][WORD_W-1-j]);
            end
        end
    endtask

    task automatic run_until_done(input int limit);
        while (obs_done.size() == 0 && obs_ab.size() == 0 && cyc < limit) tick();
        repeat (2) tick();
    endtask

    task automatic test_reset();
        prog_reset = 1'b1;
        begin_test();
        repeat (2) tick();
        n_vec++;
        if ({s_ready, ccff_head, ccff_clk_en, busy, done, aborted} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 000000", {s_ready, ccff_head, ccff_clk_en, busy, done, aborted});
        end
        n_vec++;
        if (bits_loaded !== '0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bits_loaded); end
        prog_reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bit bad;
        begin_test();
        basic_words(0, 0);
        start = 1'b1;
        run_until_done(60);
        bad = (obs_en.size() != CHAIN_LEN);
        for (int i = 0; i < obs_en.size() && !bad; i++)
            if (obs_en[i] != 2 + i || obs_bit[i] != ref_bits[CHAIN_LEN-1-i]) bad = 1;
        n_vec++;
        if (bad) begin n_err++; $display("FAIL basic_stream: got %0d shift cycles, want cycles 2..21 with bits %b", obs_en.size(), ref_bits); end
        n_vec++;
        if (obs_done.size() != 1 || obs_done[0] != 22) begin n_err++; $display("FAIL basic_done: got %0d pulses first@%0d want 1@22", obs_done.size(), (obs_done.size() > 0) ? obs_done[0] : -1); end
        n_vec++;
        if (bits_loaded !== CNT_W'(CHAIN_LEN) || busy !== 1'b0) begin n_err++; $display("FAIL basic_final: got bits_loaded=%0d busy=%b want 20 0", bits_loaded, busy); end
    endtask

    task automatic test_starvation();
        bit bad;
        begin_test();
        basic_words(15, 15);
        start = 1'b1;
        run_until_done(80);
        bad = (obs_en.size() != CHAIN_LEN);
        for (int i = 0; i < obs_en.size() && !bad; i++)
            if (obs_en[i] != ((i < 8) ? 2 + i : 8 + i) || obs_bit[i] != ref_bits[CHAIN_LEN-1-i]) bad = 1;
        n_vec++;
        if (bad) begin n_err++; $display("FAIL starve_stream: got %0d shift cycles, want 2..9 and 16..27 with unchanged bits", obs_en.size()); end
        n_vec++;
        if (obs_done.size() != 1 || obs_done[0] != 28) begin n_err++; $display("FAIL starve_done: got %0d pulses first@%0d want 1@28", obs_done.size(), (obs_done.size() > 0) ? obs_done[0] : -1); end
    endtask

    task automatic test_abort();
        begin_test();
        basic_words(0, 0);
        start = 1'b1;
        while (cyc < 7) tick();
        abort = 1'b1;
        tick();
        n_vec++;
        if ({aborted, busy, s_ready} !== 3'b100 || bits_loaded !== CNT_W'(5)) begin
            n_err++;
            $display("FAIL abort_state: got aborted=%b busy=%b s_ready=%b bits=%0d want 1 0 0 5", aborted, busy, s_ready, bits_loaded);
        end
        repeat (30) tick();
        n_vec++;
        if (obs_done.size() != 0 || obs_ab.size() != 1 || bits_loaded !== CNT_W'(5)) begin
            n_err++;
            $display("FAIL abort_after: got done=%0d aborted=%0d bits=%0d want 0 1 5", obs_done.size(), obs_ab.size(), bits_loaded);
        end
    endtask

    task automatic test_start_while_busy();
        begin_test();
        basic_words(0, 0);
        start = 1'b1;
        while (cyc < 5) tick();
        start = 1'b1;
        run_until_done(60);
        repeat (10) tick();
        n_vec++;
        if (obs_done.size() != 1 || obs_done[0] != 22 || obs_en.size() != CHAIN_LEN || busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_start: got done=%0d first@%0d shifts=%0d busy=%b want 1@22 20 0", obs_done.size(), (obs_done.size() > 0) ? obs_done[0] : -1, obs_en.size(), busy);
        end
    endtask

    task automatic test_reset_midload();
        bit bad;
        begin_test();
        basic_words(0, 0);
        start = 1'b1;
        while (cyc < 10) tick();
        prog_reset = 1'b1;
        tick();
        prog_reset = 1'b0;
        n_vec++;
        if ({s_ready, ccff_head, ccff_clk_en, busy, done, aborted} !== 6'b0 || bits_loaded !== '0) begin
            n_err++;
            $display("FAIL midreset: got flags=%b bits=%0d want 000000 0", {s_ready, ccff_head, ccff_clk_en, busy, done, aborted}, bits_loaded);
        end
        begin_test();
        basic_words(0, 0);
        start = 1'b1;
        run_until_done(60);
        bad = (obs_en.size() != CHAIN_LEN) || obs_ab.size() != 0;
        for (int i = 0; i < obs_en.size() && !bad; i++)
            if (obs_bit[i] != ref_bits[CHAIN_LEN-1-i]) bad = 1;
        n_vec++;
        if (bad || obs_done.size() != 1 || obs_done[0] != 22) begin n_err++; $display("FAIL reload_after_reset: got shifts=%0d done=%0d want 20 1@22", obs_en.size(), obs_done.size()); end
    endtask

    task automatic test_idle_abort();
        begin_test();
        abort = 1'b1;
        tick();
        tick();
        n_vec++;
        if (obs_ab.size() != 0 || busy !== 1'b0) begin n_err++; $display("FAIL idle_abort: got pulses=%0d busy=%b want 0 0", obs_ab.size(), busy); end
        basic_words(0, 0);
        start = 1'b1;
        abort = 1'b1;
        tick();
        n_vec++;
        if (busy !== 1'b1 || aborted !== 1'b0) begin n_err++; $display("FAIL start_beats_abort: got busy=%b aborted=%b want 1 0", busy, aborted); end
        run_until_done(80);
        n_vec++;
        if (obs_done.size() != 1 || obs_ab.size() != 0 || bits_loaded !== CNT_W'(CHAIN_LEN)) begin
            n_err++;
            $display("FAIL start_beats_abort_load: got done=%0d aborted=%0d bits=%0d want 1 0 20", obs_done.size(), obs_ab.size(), bits_loaded);
        end
    endtask

    task automatic test_random_stream();
        int s;
        bit bad;
        for (int it = 0; it < 25; it++) begin
            begin_test();
            s = $urandom_range(0, 3);
            random_words(3 + $urandom_range(0, 1), $urandom_range(0, 12));
            build_model(s);
            repeat (s) tick();
            start = 1'b1;
            run_until_done(300);
            bad = (obs_en.size() != exp_t.size());
            for (int i = 0; i < obs_en.size() && !bad; i++)
                if (obs_en[i] != exp_t[i] || obs_bit[i] != exp_b[i]) bad = 1;
            n_vec++;
            if (bad) begin n_err++; $display("FAIL rand_stream it%0d: got %0d shifts first@%0d want %0d first@%0d", it, obs_en.size(), (obs_en.size() > 0) ? obs_en[0] : -1, exp_t.size(), exp_t[0]); end
            n_vec++;
            if (obs_done.size() != 1 || obs_done[0] != exp_t[CHAIN_LEN-1] + 1 || bits_loaded !== CNT_W'(CHAIN_LEN)) begin
                n_err++;
                $display("FAIL rand_done it%0d: got %0d pulses first@%0d bits=%0d want 1@%0d 20", it, obs_done.size(), (obs_done.size() > 0) ? obs_done[0] : -1, bits_loaded, exp_t[CHAIN_LEN-1] + 1);
            end
        end
    endtask

    task automatic test_random_abort();
        int s, c, want;
        for (int it = 0; it < 10; it++) begin
            begin_test();
            s = $urandom_range(0, 3);
            random_words(3, $urandom_range(0, 10));
            build_model(s);
            c = $urandom_range(s + 1, exp_t[CHAIN_LEN-1]);
            want = 0;
            foreach (exp_t[i]) if (exp_t[i] < c) want++;
            repeat (s) tick();
            start = 1'b1;
            while (cyc < c) tick();
            abort = 1'b1;
            tick();
            n_vec++;
            if (aborted !== 1'b1 || busy !== 1'b0 || bits_loaded !== CNT_W'(want)) begin
                n_err++;
                $display("FAIL rand_abort it%0d: at cycle %0d got aborted=%b busy=%b bits=%0d want 1 0 %0d", it, cyc, aborted, busy, bits_loaded, want);
            end
            repeat (5) tick();
            n_vec++;
            if (obs_done.size() != 0 || obs_ab.size() != 1) begin n_err++; $display("FAIL rand_abort_pulses it%0d: got done=%0d aborted=%0d want 0 1", it, obs_done.size(), obs_ab.size()); end
        end
    endtask

`ifdef CCFF_TAIL_CRC_EN
    task automatic test_tail_crc();
        logic [15:0] crc;
        crc = 16'hFFFF;
        for (int i = CHAIN_LEN - 1; i >= 0; i--)
            crc = {crc[14:0], 1'b0} ^ ((crc[15] ^ ref_bits[i]) ? 16'h1021 : 16'h0000);
        for (int l = 0; l < 2; l++) begin
            begin_test();
            basic_words(0, 0);
            start = 1'b1;
            run_until_done(60);
        end
        n_vec++;
        if (tail_crc !== crc) begin n_err++; $display("FAIL tail_crc: got %h want %h", tail_crc, crc); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_starvation();
        test_abort();
        test_start_while_busy();
        test_reset_midload();
        test_idle_abort();
        test_random_stream();
        test_random_abort();
`ifdef CCFF_TAIL_CRC_EN
        test_tail_crc();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
